// File: rtl/unit_fetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package unit_fetch_pkg;

    localparam int BUS_W  = 32;
    localparam int INST_W = 32;

    localparam logic [BUS_W-1:0] RESET_PC_DEF = 32'h0000_0000;

    // RUN: no stale responses pending. DRAIN: discarding responses to
    // requests issued before the last redirect.
    typedef enum logic {
        FETCH_RUN   = 1'b0,
        FETCH_DRAIN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/unit_fetch_fifo.sv
// Synchronous instruction buffer holding {pc, instruction} pairs.
// Clear has priority over push and pop.
module unit_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    input  logic                       clear,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage array: written on accepted push.
    // NOTE: the data array has no reset; only pointers and count need one,
    // and leaving it out lets the array map onto plain registers/RAM.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/unit_fetch.sv
// Instruction-fetch unit: owns the fetch PC, issues in-order word fetches,
// buffers returned instructions with their PC, and handles jump redirects
// by flushing the buffer and discarding responses to stale requests.
module unit_fetch
    import unit_fetch_pkg::*;
#(
    parameter logic [BUS_W-1:0] RESET_PC  = RESET_PC_DEF,
    parameter int               BUF_DEPTH = 2
) (
    input  logic              clk_in,
    input  logic              rstn_in,
    input  logic              jumpEn_in,
    input  logic [BUS_W-1:0]  jumpAddr_in,
    output logic              imemReq_out,
    output logic [BUS_W-1:0]  imemAddr_out,
    input  logic              imemGnt_in,
    input  logic              imemRvalid_in,
    input  logic [INST_W-1:0] imemRdata_in,
    output logic              instValid_out,
    output logic [INST_W-1:0] inst_out,
    output logic [BUS_W-1:0]  instPc_out,
    input  logic              instReady_in,
    output logic              flush_out,
    output logic              jumpMisalign_out
);

    localparam int          CW      = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);

    fetch_state_t           state, state_nxt;
    logic [CW-1:0]          kill_cnt, kill_nxt;
    logic [CW-1:0]          outstanding, out_nxt;
    logic [BUS_W-1:0]       fetch_pc;
    logic [BUS_W-1:0]       pc_tag;
    logic [BUS_W-1:0]       jump_target;
    logic                   run_q;
    logic                   fire;
    logic                   push;
    logic                   pop;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [BUS_W+INST_W-1:0] fifo_head;
    logic [CW:0]            in_use;

    assign jump_target = {jumpAddr_in[BUS_W-1:2], 2'b00};
    assign in_use      = {1'b0, outstanding} + {1'b0, fifo_count};

    // A request is only made when a buffer slot is guaranteed for its response.
    assign imemReq_out  = run_q && !jumpEn_in && (in_use < DEPTH_C);
    assign imemAddr_out = fetch_pc;
    assign fire         = imemReq_out && imemGnt_in;

    // Responses are buffered only when no stale responses remain and no
    // redirect is clearing the buffer this cycle.
    assign push = imemRvalid_in && (state == FETCH_RUN) && !jumpEn_in;
    assign pop  = instValid_out && instReady_in && !jumpEn_in;

    assign out_nxt = outstanding + CW'(fire) - CW'(imemRvalid_in);

    assign instValid_out = !fifo_empty;
    assign inst_out      = instValid_out ? fifo_head[INST_W-1:0] : '0;
    assign instPc_out    = instValid_out ? fifo_head[BUS_W+INST_W-1:INST_W] : '0;

    unit_fetch_fifo #(
        .WIDTH (BUS_W + INST_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk_in),
        .rst_n (rstn_in),
        .push  (push),
        .wdata ({pc_tag, imemRdata_in}),
        .pop   (pop),
        .clear (jumpEn_in),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Kill-count FSM: next state and next kill count.
    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        kill_nxt  = kill_cnt;
        if (jumpEn_in) begin
            kill_nxt  = out_nxt;
            state_nxt = (out_nxt != '0) ? FETCH_DRAIN : FETCH_RUN;
        end else begin
            case (state)
                FETCH_DRAIN: begin
                    if (imemRvalid_in) begin
                        kill_nxt = kill_cnt - CW'(1);
                        if (kill_cnt == CW'(1)) state_nxt = FETCH_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    // Kill-count FSM state register.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state    <= FETCH_RUN;
            kill_cnt <= '0;
        end else begin
            state    <= state_nxt;
            kill_cnt <= kill_nxt;
        end
    end

    // Fetch PC, response PC tag, credit count and redirect pulses.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            fetch_pc         <= RESET_PC;
            pc_tag           <= RESET_PC;
            outstanding      <= '0;
            run_q            <= 1'b0;
            flush_out        <= 1'b0;
            jumpMisalign_out <= 1'b0;
        end else begin
            run_q            <= 1'b1;
            outstanding      <= out_nxt;
            flush_out        <= jumpEn_in;
            jumpMisalign_out <= jumpEn_in && (jumpAddr_in[1:0] != 2'b00);
            if (jumpEn_in) begin
                fetch_pc <= jump_target;
                pc_tag   <= jump_target;
            end else begin
                if (fire) fetch_pc <= fetch_pc + BUS_W'(4);
                if (push) pc_tag   <= pc_tag + BUS_W'(4);
            end
        end
    end

    // Credit accounting must keep the buffer from ever overflowing.
    assert property (@(posedge clk_in) disable iff (!rstn_in)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_unit_fetch.sv
// Self-checking bench for unit_fetch: a memory model answers granted
// requests in order; a scoreboard of expected {pc, inst} pairs is filled
// from non-stale responses and compared as decode consumes the buffer.
module tb_unit_fetch;
    import unit_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        ready;
    logic        flush;
    logic        misalign;

    always #5 clk = ~clk;

    unit_fetch #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (2)
    ) dut (
        .clk_in           (clk),
        .rstn_in          (rstn),
        .jumpEn_in        (jump_en),
        .jumpAddr_in      (jump_addr),
        .imemReq_out      (req),
        .imemAddr_out     (addr),
        .imemGnt_in       (gnt),
        .imemRvalid_in    (rvalid),
        .imemRdata_in     (rdata),
        .instValid_out    (inst_valid),
        .inst_out         (inst),
        .instPc_out       (inst_pc),
        .instReady_in     (ready),
        .flush_out        (flush),
        .jumpMisalign_out (misalign)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_pc;
        int          epoch;
    } pend_t;

    pend_t       pend_q[$];
    logic [63:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          epoch    = 0;
    int          fires    = 0;
    logic [31:0] exp_fetch;
    logic        prev_jump;
    logic        prev_mis;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle(input logic jmp, input logic [31:0] jaddr,
                         input logic g, input logic resp, input logic rdy);
        pend_t       p;
        logic        got_resp;
        logic [63:0] e;
        jump_en   = jmp;
        jump_addr = jaddr;
        gnt       = g;
        ready     = rdy;
        rvalid    = 1'b0;
        rdata     = '0;
        got_resp  = 1'b0;
        p         = '{addr: '0, exp_pc: '0, epoch: 0};
        if (resp && pend_q.size() > 0) begin
            p        = pend_q.pop_front();
            rvalid   = 1'b1;
            rdata    = mem_word(p.addr);
            got_resp = 1'b1;
        end
        #1;
        check("flush", {31'b0, flush}, {31'b0, prev_jump});
        check("misalign", {31'b0, misalign}, {31'b0, prev_mis});
        check("inst_valid", {31'b0, inst_valid}, {31'b0, exp_q.size() > 0});
        if (jmp) check("req_in_jump", {31'b0, req}, 32'd0);
        if (prev_jump) check("redirect_addr", addr, exp_fetch);
        if (inst_valid && rdy && !jmp && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("inst_pc", inst_pc, e[63:32]);
            check("inst", inst, e[31:0]);
        end
        if (req && g) begin
            check("fetch_addr", addr, exp_fetch);
            pend_q.push_back('{addr: addr, exp_pc: exp_fetch, epoch: epoch});
            exp_fetch = exp_fetch + 32'd4;
            fires++;
        end
        if (got_resp && !jmp && p.epoch == epoch)
            exp_q.push_back({p.exp_pc, mem_word(p.exp_pc)});
        if (jmp) begin
            exp_q.delete();
            epoch++;
            exp_fetch = {jaddr[31:2], 2'b00};
        end
        prev_jump = jmp;
        prev_mis  = jmp && (jaddr[1:0] != 2'b00);
        @(negedge clk);
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases it.
    task automatic do_reset();
        #2;
        rstn    = 1'b0;
        jump_en = 1'b0;
        gnt     = 1'b0;
        rvalid  = 1'b0;
        ready   = 1'b0;
        #1;
        check("rst_req", {31'b0, req}, 32'd0);
        check("rst_addr", addr, RST_PC);
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_pc", inst_pc, 32'd0);
        check("rst_flush", {31'b0, flush}, 32'd0);
        check("rst_misalign", {31'b0, misalign}, 32'd0);
        pend_q.delete();
        exp_q.delete();
        epoch++;
        exp_fetch = RST_PC;
        prev_jump = 1'b0;
        prev_mis  = 1'b0;
        fires     = 0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn      = 1'b0;
        jump_en   = 1'b0;
        jump_addr = '0;
        gnt       = 1'b0;
        rvalid    = 1'b0;
        rdata     = '0;
        ready     = 1'b0;
        exp_fetch = RST_PC;
        prev_jump = 1'b0;
        prev_mis  = 1'b0;
        @(negedge clk);
        do_reset();

        // Streaming with single-cycle memory latency.
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // Decode stalled: exactly two requests fit, then requests stop.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("stall_fires", fires, 32'd2);
        check("stall_req", {31'b0, req}, 32'd0);
        check("stall_addr", addr, 32'h8);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // Two stale requests outstanding (0x10, 0x14) at the redirect to 0x100.
        cycle(1'b1, 32'h10, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        fires = 0;
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("two_outstanding", fires, 32'd2);
        cycle(1'b1, 32'h100, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // Redirect in the same cycle as a grant and a response.
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h40, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // Misaligned target: pulse, then fetch resumes at 0x200.
        cycle(1'b1, 32'h202, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // Fetch PC wraps past the top of the address space.
        cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // Reset mid-flight, then restart at RESET_PC.
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // Random traffic: grants, latencies, stalls and redirects.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 19) == 0), $urandom,
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
